// File: rtl/skew_feeder.sv
// skew_feeder: re-times per-lane beats from a FIFO_Q bank into the diagonal
// wavefront a systolic array expects (lane i delayed i cycles after lane 0),
// counts a commanded burst, flags misaligned lanes and zero-fills bubbles.
// Optional build macro SKEW_FEEDER_REVERSE_EN mirrors the skew so that lane
// LANES-1 leads and lane 0 trails.

// One lane's delay chain: valid and data shift together, so invalid slots
// always carry zero data.
module skew_lane #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);
  logic [DEPTH-1:0]        vld_pipe;
  logic [DEPTH-1:0][W-1:0] dat_pipe;

  // shift valid and data down the chain each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      dat_pipe[0] <= in_dat;
      for (int k = 1; k < DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign out_vld = vld_pipe[DEPTH-1];
  assign out_dat = dat_pipe[DEPTH-1];
endmodule

module skew_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        len,
  input  logic [LANES-1:0]            in_valid,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic [LANES-1:0]            out_valid,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // drain counter runs 0..LANES-2 so DRAIN lasts LANES-1 cycles
  localparam int DCW = (LANES > 2) ? $clog2(LANES - 1) : 1;
  localparam logic [DCW-1:0] DLAST = DCW'(LANES - 2);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt, len_q, cnt_nxt;
  logic [DCW-1:0]       dcnt;
  logic                 start_ok, accept, misal;

  // start is honoured only in IDLE and not during the trailing done cycle
  assign start_ok = (state == S_IDLE) && start && !busy;
  assign accept   = (state == S_RUN) && (&in_valid);
  assign misal    = (state == S_RUN) && (|in_valid) && !(&in_valid);
  // cnt < len_q <= max while in RUN, so this never wraps
  assign cnt_nxt  = cnt + 1'b1;

  // burst control FSM: beat counting, drain timing, done/busy/err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      len_q <= '0;
      dcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            err <= 1'b0;
            cnt <= '0;
            if (len != '0) begin
              len_q <= len;
              busy  <= 1'b1;
              state <= S_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (misal) err <= 1'b1;
          if (accept) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state <= S_DRAIN;
              dcnt  <= '0;
            end
          end
        end
        S_DRAIN: begin
          // exit lines up with the last beat leaving the trailing lane
          if (dcnt == DLAST) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // per-lane delay chains; rejected beats enter as zero/invalid
  for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef SKEW_FEEDER_REVERSE_EN
    localparam int DEPTH = LANES - i;
`else
    localparam int DEPTH = i + 1;
`endif
    logic [DATA_WIDTH-1:0] lane_in;
    assign lane_in = accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

    skew_lane #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (accept),
      .in_dat  (lane_in),
      .out_vld (out_valid[i]),
      .out_dat (out_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder (LANES=4, DATA_WIDTH=32, CNT_WIDTH=8).
module tb_skew_feeder;
  localparam int L  = 4;
  localparam int DW = 32;
  localparam int CW = 8;
`ifdef SKEW_FEEDER_REVERSE_EN
  localparam int FL = 3, ML = 2, LL = 0;
`else
  localparam int FL = 0, ML = 1, LL = 3;
`endif

  logic            clk = 0;
  logic            rst;
  logic            start;
  logic [CW-1:0]   len;
  logic [L-1:0]    in_valid;
  logic [L*DW-1:0] in_data;
  logic [L-1:0]    out_valid;
  logic [L*DW-1:0] out_data;
  logic            busy, done, err;

  int n_chk = 0;
  int n_err = 0;
  int vcnt, dsum;

  skew_feeder #(.DATA_WIDTH(DW), .LANES(L), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] od(input int i);
    return out_data[i*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [L-1:0] v, input logic [DW-1:0] base);
    in_valid = v;
    for (int i = 0; i < L; i++) in_data[i*DW +: DW] = base + DW'(i);
  endtask

  initial begin
    rst = 1; start = 0; len = '0; in_valid = '0; in_data = '0;
    #1;
    chk("rst_ovalid", 64'(out_valid), 64'h0);
    chk("rst_odata",  64'(out_data[63:0]), 64'h0);
    chk("rst_busy",   64'(busy), 64'h0);
    chk("rst_done",   64'(done), 64'h0);
    chk("rst_err",    64'(err), 64'h0);
    step(); rst = 0;

    // contiguous burst, len=3
    start = 1; len = 3; step(); start = 0;
    chk("c_busy0", 64'(busy), 64'h1);
    beat('1, 32'h00); step(); chk("c_l0_b0", 64'(od(FL)), 64'(32'h00 + FL));
    beat('1, 32'h10); step(); chk("c_l0_b1", 64'(od(FL)), 64'(32'h10 + FL));
    beat('1, 32'h20); step(); chk("c_l0_b2", 64'(od(FL)), 64'(32'h20 + FL));
    beat('0, 32'h00);
    step(); chk("c_l3_b0", 64'(od(LL)), 64'(32'h00 + LL)); chk("c_done_early", 64'(done), 64'h0);
    step(); chk("c_l3_b1", 64'(od(LL)), 64'(32'h10 + LL));
    step(); chk("c_l3_b2", 64'(od(LL)), 64'(32'h20 + LL));
    chk("c_done", 64'(done), 64'h1); chk("c_busy_done", 64'(busy), 64'h1);
    step(); chk("c_done_clr", 64'(done), 64'h0); chk("c_busy_clr", 64'(busy), 64'h0);

    // bubbles, len=2
    start = 1; len = 2; step(); start = 0;
    beat('1, 32'h100); step();
    chk("b_v0", 64'(out_valid[FL]), 64'h1); chk("b_d0", 64'(od(FL)), 64'(32'h100 + FL));
    beat('0, 32'hDEAD0); step();
    chk("b_gap_v", 64'(out_valid[FL]), 64'h0); chk("b_gap_d", 64'(od(FL)), 64'h0);
    chk("b_mid", 64'(od(ML)), 64'(32'h100 + ML));
    beat('1, 32'h200); step();
    chk("b_v2", 64'(out_valid[FL]), 64'h1); chk("b_d2", 64'(od(FL)), 64'(32'h200 + FL));
    chk("b_mid_gap", 64'(od(ML)), 64'h0);
    beat('0, 32'h0);
    step(); step(); chk("b_done_early", 64'(done), 64'h0);
    step(); chk("b_done", 64'(done), 64'h1); chk("b_l3", 64'(od(LL)), 64'(32'h200 + LL));
    chk("b_err", 64'(err), 64'h0);
    step();

    // misalignment, len=2
    start = 1; len = 2; step(); start = 0;
    beat(4'b0111, 32'h300); step();
    chk("m_err", 64'(err), 64'h1); chk("m_part_v", 64'(out_valid), 64'h0);
    beat('1, 32'h400); step(); chk("m_b0", 64'(od(FL)), 64'(32'h400 + FL));
    beat('1, 32'h500); step(); chk("m_b1", 64'(od(FL)), 64'(32'h500 + FL));
    beat('0, 32'h0);
    step(); chk("m_part_l3v", 64'(out_valid[LL]), 64'h0); chk("m_part_l3d", 64'(od(LL)), 64'h0);
    step(); chk("m_l3_b0", 64'(od(LL)), 64'(32'h400 + LL));
    step(); chk("m_done", 64'(done), 64'h1); chk("m_l3_b1", 64'(od(LL)), 64'(32'h500 + LL));
    chk("m_err_sticky", 64'(err), 64'h1);
    step();

    // zero length: done next cycle, busy stays low, err cleared
    start = 1; len = 0; step(); start = 0;
    chk("z_done", 64'(done), 64'h1); chk("z_busy", 64'(busy), 64'h0); chk("z_err", 64'(err), 64'h0);
    step(); chk("z_done_clr", 64'(done), 64'h0);

    // busy start ignored: len=4, start len=1 mid-burst, extra beats in drain dropped
    start = 1; len = 4; step(); start = 0;
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      beat('1, 32'h700 + 32'(k*16));
      if (k == 1) begin start = 1; len = 1; end else start = 0;
      step();
      if (out_valid[FL]) vcnt++;
    end
    beat('0, 32'h0); start = 0;
    chk("bs_beats", 64'(vcnt), 64'd4);
    step(); chk("bs_done", 64'(done), 64'h1); chk("bs_l3", 64'(od(LL)), 64'(32'h730 + LL));
    step(); step(); chk("bs_idle_v", 64'(out_valid), 64'h0);

    // reset mid-burst
    start = 1; len = 5; step(); start = 0;
    beat('1, 32'h800); step();
    beat('1, 32'h810); step();
    beat('1, 32'h820);
    #2; rst = 1; #1;
    chk("r_ovalid", 64'(out_valid), 64'h0); chk("r_odata", 64'(out_data[63:0]), 64'h0);
    chk("r_busy", 64'(busy), 64'h0); chk("r_done", 64'(done), 64'h0);
    step(); rst = 0; beat('0, 32'h0);
    dsum = 0;
    for (int k = 0; k < 5; k++) begin step(); dsum += int'(done); end
    chk("r_no_done", 64'(dsum), 64'd0); chk("r_busy_after", 64'(busy), 64'h0);
    start = 1; len = 1; step(); start = 0;
    beat('1, 32'h900); step(); chk("r2_l0", 64'(od(FL)), 64'(32'h900 + FL));
    beat('0, 32'h0);
    step(); step(); chk("r2_done_early", 64'(done), 64'h0);
    step(); chk("r2_done", 64'(done), 64'h1);
    chk("r2_l3", 64'(od(LL)), 64'(32'h900 + LL)); chk("r2_l3v", 64'(out_valid[LL]), 64'h1);
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
- Sits directly downstream of a bank of LANES FIFO_Q queues, one queue per systolic-array row.
- Takes the per-lane (valid, data) beats the queues emit and re-times them into the diagonal wavefront the systolic array needs: lane i is delayed i cycles relative to lane 0.
- Counts a commanded burst length and flags misaligned lanes.
- Zero-fills bubbles so the array only ever sees zeros when a lane is not valid.

Parameters:
- DATA_WIDTH, 32, width of one lane word.
- LANES, 4, number of lanes / array rows (>=2).
- CNT_WIDTH, 8, width of burst-length counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  burst command pulse; sampled only in IDLE.
- len  in  CNT_WIDTH  burst length in beats; latched with start.
- in_valid  in  LANES  per-lane valid from the FIFO_Q bank.
- in_data  in  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  LANES  skewed per-lane valid to the array.
- out_data  out  LANES*DATA_WIDTH  skewed per-lane data, same packing as in_data.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  sticky misalignment flag.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset: out_valid=0, out_data=0, busy=0, done=0, err=0, all delay stages cleared, state=IDLE, beat counter=0. Asserting rst mid-burst aborts immediately; no done pulse is generated.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with len!=0: latch len, clear err and counter, go to RUN.
  - start=1 with len==0: done=1 next cycle, err cleared, stay in IDLE.
  - in_valid is ignored in IDLE; beats are dropped and no err is raised.
- RUN, per edge:
  - in_valid all ones: beat accepted, counter+1.
  - in_valid==0: bubble; nothing accepted.
  - Any other in_valid pattern: beat discarded, err<=1 (sticky until next accepted start), counter unchanged.
  - When the accepted count reaches the latched len, go to DRAIN on that same edge.
- DRAIN: lasts LANES-1 cycles, then returns to IDLE. Beats arriving in DRAIN are dropped without err.
- Skew and latency: a beat accepted at edge E appears on lane i during the cycle after edge E+i.
  - Lane 0 latency is 1 cycle; lane LANES-1 latency is LANES cycles.
  - Each lane is a shift chain of depth i+1 that carries a valid bit with the data.
- Bubble fill: out_data lane i = 0 whenever out_valid[i]=0. Discarded and bubble beats propagate as zero/invalid through all lanes.
- Completion:
  - done=1 for exactly the cycle in which out_valid[LANES-1] carries the last beat.
  - busy=1 from the cycle after the accepted start through the done cycle inclusive.
- Busy start: start while busy=1 is ignored; len is not re-latched.
- Counter arithmetic: unsigned CNT_WIDTH; maximum burst is 2^CNT_WIDTH-1; counter never wraps within a burst.
- Back-to-back bursts: a new start is accepted in the first IDLE cycle after done.

Optional Feature:
- Macro: SKEW_FEEDER_REVERSE_EN.
- Defined: skew is mirrored, lane i is delayed LANES-1-i extra cycles (lane LANES-1 latency 1, lane 0 latency LANES). done aligns with the last beat on lane 0.
- Undefined: normal skew as above. All other behaviour is identical in both builds.

Test Plan:
- Reset mid-burst: LANES=4, len=5, rst pulsed after 2 accepted beats -> all outputs 0 on rst assertion, no done; a new start with len=1 afterwards completes normally with done after 4 cycles.
- Contiguous burst: len=3, in_valid=4'b1111 for 3 cycles, lane i data = 16*beat+i -> lane 0 outputs 0x00,0x10,0x20 on cycles 1-3; lane 3 outputs 0x03,0x13,0x23 on cycles 4-6; done=1 on cycle 6; busy high cycles 1-6.
- Bubbles: len=2, in_valid 1111,0000,1111 -> lane 0 valid pattern 1,0,1 with out_data=0 in the gap; err=0; done when lane 3 emits beat 2.
- Misalignment: len=2, in_valid=4'b0111 once then 1111 twice -> err=1 and stays 1; the partial beat never appears on any lane; done after 2 good beats; next start clears err.
- Zero length and busy start: start with len=0 -> done one cycle later, busy stays 0. During a len=4 burst, start with len=1 -> ignored, exactly 4 beats are emitted.
- REVERSE build: len=1, data lane i = 0xA0+i -> lane 3 emits 0xA3 at latency 1, lane 0 emits 0xA0 at latency 4, done coincides with the lane 0 output.
